// File: rtl/alu_pkg.sv
// Shared constants for the handshaked ALU datapath: opcodes, FSM encoding,
// flag bit positions and a flag packing helper.
package alu_pkg;

   typedef logic [3:0] flags_t;
   typedef logic [3:0] opcode_t;

   localparam opcode_t OP_ADD  = 4'd0;
   localparam opcode_t OP_SUB  = 4'd1;
   localparam opcode_t OP_AND  = 4'd2;
   localparam opcode_t OP_OR   = 4'd3;
   localparam opcode_t OP_XOR  = 4'd4;
   localparam opcode_t OP_NOT  = 4'd5;
   localparam opcode_t OP_SHL  = 4'd6;
   localparam opcode_t OP_SHR  = 4'd7;
   localparam opcode_t OP_MUL  = 4'd8;
   localparam opcode_t OP_PASS = 4'd9;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_MUL  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   function automatic flags_t pack_flags(input logic v, input logic c,
                                         input logic n, input logic z);
      flags_t f;
      f         = 4'b0000;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/alu_datapath_seq_if.sv
// Control/handshake bundle between a bus master and the ALU datapath.
// The tri-state result drive stays a plain port on the datapath itself.
interface alu_datapath_seq_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] bus_in;
   logic             load_a;
   logic             load_b;
   logic [3:0]       op;
   logic             acc_chain;
   logic             start;
   logic             out_en;
   logic             busy;
   logic             done;
   logic [3:0]       flags;

   modport master (
      output bus_in, load_a, load_b, op, acc_chain, start, out_en,
      input  busy, done, flags
   );

   modport slave (
      input  bus_in, load_a, load_b, op, acc_chain, start, out_en,
      output busy, done, flags
   );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU ops. legal=0 flags an opcode this core does
// not execute (MUL and 10-15), leaving the caller to hold its state.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             legal
);

   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] res_s;
   logic             c_s;
   logic             v_s;

   assign sum_s = {1'b0, a} + {1'b0, b};

   // Opcode decode; C/V defaults cover the logic ops that leave them clear.
   always_comb begin
      res_s = {WIDTH{1'b0}};
      c_s   = 1'b0;
      v_s   = 1'b0;
      legal = 1'b1;
      case (op)
         OP_ADD: begin
            res_s = sum_s[WIDTH-1:0];
            c_s   = sum_s[WIDTH];
            v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (res_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res_s = a - b;
            c_s   = (a < b);
            v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (res_s[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  res_s = a & b;
         OP_OR:   res_s = a | b;
         OP_XOR:  res_s = a ^ b;
         OP_NOT:  res_s = ~a;
         OP_SHL: begin
            res_s = {a[WIDTH-2:0], 1'b0};
            c_s   = a[WIDTH-1];
         end
         OP_SHR: begin
            res_s = {1'b0, a[WIDTH-1:1]};
            c_s   = a[0];
         end
         OP_PASS: res_s = b;
         default: legal = 1'b0;
      endcase
   end

   assign result = res_s;
   assign flags  = pack_flags(v_s, c_s, res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}));

endmodule

// File: rtl/alu_datapath_seq.sv
// Handshaked ALU datapath: bus-loaded operand registers, IDLE/EXEC/MUL/DONE
// sequencer, shift-add multiplier, registered result/flags and tri-state drive.
module alu_datapath_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   alu_datapath_seq_if.slave bif,
   output logic [WIDTH-1:0] bus_out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]         state_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [WIDTH-1:0]   opa_r;
   logic [WIDTH-1:0]   opb_r;
   logic [3:0]         op_r;
   logic [WIDTH-1:0]   result_r;
   logic [3:0]         flags_r;
   logic               busy_r;
   logic               done_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [2*WIDTH-1:0] prod_r;

   logic [WIDTH-1:0]   opa_sel_s;
   logic               start_mul_s;
   logic [2*WIDTH-1:0] prod_next_s;
   logic [3:0]         mul_flags_s;
   logic [WIDTH-1:0]   core_res_s;
   logic [3:0]         core_flags_s;
   logic               core_legal_s;

   alu_comb_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_r),
      .a      (opa_r),
      .b      (opb_r),
      .result (core_res_s),
      .flags  (core_flags_s),
      .legal  (core_legal_s)
   );

   // Launch decode and next partial product of the shift-add engine.
   always_comb begin
      opa_sel_s   = bif.acc_chain ? result_r : a_r;
      start_mul_s = (bif.op == OP_MUL) && (MUL_EN != 0);
      if (mplier_r[0]) begin
         prod_next_s = prod_r + mcand_r;
      end else begin
         prod_next_s = prod_r;
      end
      mul_flags_s = pack_flags(1'b0, |prod_next_s[2*WIDTH-1:WIDTH],
                               prod_next_s[WIDTH-1],
                               (prod_next_s[WIDTH-1:0] == {WIDTH{1'b0}}));
   end

   // Sequencer, operand/result registers and multiply datapath.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         opa_r    <= {WIDTH{1'b0}};
         opb_r    <= {WIDTH{1'b0}};
         op_r     <= 4'd0;
         result_r <= {WIDTH{1'b0}};
         flags_r  <= 4'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
         mcand_r  <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         prod_r   <= {(2*WIDTH){1'b0}};
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bif.load_a) a_r <= bif.bus_in;
               if (bif.load_b) b_r <= bif.bus_in;
               // Operands captured here are the pre-load values, so a load on the
               // launch edge only affects the next op.
               if (bif.start) begin
                  op_r   <= bif.op;
                  opa_r  <= opa_sel_s;
                  opb_r  <= b_r;
                  busy_r <= 1'b1;
                  if (start_mul_s) begin
                     state_r  <= ST_MUL;
                     mcand_r  <= {{WIDTH{1'b0}}, opa_sel_s};
                     mplier_r <= b_r;
                     prod_r   <= {(2*WIDTH){1'b0}};
                     cnt_r    <= {CNT_W{1'b0}};
                  end else begin
                     state_r <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               if (core_legal_s) begin
                  result_r <= core_res_s;
                  flags_r  <= core_flags_s;
               end
               state_r <= ST_DONE;
               done_r  <= 1'b1;
            end
            ST_MUL: begin
               prod_r   <= prod_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_LAST) begin
                  result_r <= prod_next_s[WIDTH-1:0];
                  flags_r  <= mul_flags_s;
                  state_r  <= ST_DONE;
                  done_r   <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bif.busy  = busy_r;
   assign bif.done  = done_r;
   assign bif.flags = flags_r;
   assign bus_out   = bif.out_en ? result_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_datapath_seq.sv
// Directed bench for alu_datapath_seq: vector table plus hand sequences for
// chaining, load/start interaction, mid-op reset, bus drive and MUL_EN=0.
module tb_alu_datapath_seq;
   import alu_pkg::*;

   logic clk;
   logic rst;
   wire [15:0] bus_out0;
   wire [15:0] bus_out1;
   int tests;
   int fails;

   alu_datapath_seq_if #(.WIDTH(16)) bif0 ();
   alu_datapath_seq_if #(.WIDTH(16)) bif1 ();

   assign bif1.bus_in    = bif0.bus_in;
   assign bif1.load_a    = bif0.load_a;
   assign bif1.load_b    = bif0.load_b;
   assign bif1.op        = bif0.op;
   assign bif1.acc_chain = bif0.acc_chain;
   assign bif1.start     = bif0.start;
   assign bif1.out_en    = bif0.out_en;

   alu_datapath_seq #(.WIDTH(16), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .bif(bif0), .bus_out(bus_out0));
   alu_datapath_seq #(.WIDTH(16), .MUL_EN(0)) dut_nomul (
      .clk(clk), .rst(rst), .bif(bif1), .bus_out(bus_out1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  op;
      logic [15:0] res;
      logic [3:0]  fl;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic get_done(input int sel);
      return (sel == 0) ? bif0.done : bif1.done;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? bif0.busy : bif1.busy;
   endfunction

   function automatic logic [15:0] get_bus(input int sel);
      return (sel == 0) ? bus_out0 : bus_out1;
   endfunction

   function automatic logic [3:0] get_flags(input int sel);
      return (sel == 0) ? bif0.flags : bif1.flags;
   endfunction

   task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
      bif0.bus_in = a;
      bif0.load_a = 1'b1;
      tick();
      bif0.load_a = 1'b0;
      bif0.bus_in = b;
      bif0.load_b = 1'b1;
      tick();
      bif0.load_b = 1'b0;
   endtask

   // Launch, wait for done (bounded), read result, then step back to IDLE.
   task automatic run_op(input int sel, input logic [3:0] op, input logic chain,
                         output logic [15:0] res, output logic [3:0] fl, output int lat);
      bif0.op        = op;
      bif0.acc_chain = chain;
      bif0.start     = 1'b1;
      tick();
      bif0.start     = 1'b0;
      bif0.acc_chain = 1'b0;
      lat = 1;
      while (get_done(sel) !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      if (get_done(sel) !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL timeout: no done within %0d cycles", lat);
      end
      res = get_bus(sel);
      fl  = get_flags(sel);
      chk("busy_at_done", {31'd0, get_busy(sel)}, 32'd1);
      tick();
      chk("done_one_cycle", {31'd0, get_done(sel)}, 32'd0);
   endtask

   initial begin
      logic [15:0] res;
      logic [3:0]  fl;
      int          lat;
      int          done_cnt;

      tests = 0;
      fails = 0;
      bif0.bus_in = 16'h0000;
      bif0.load_a = 1'b0;
      bif0.load_b = 1'b0;
      bif0.op = 4'd0;
      bif0.acc_chain = 1'b0;
      bif0.start = 1'b0;
      bif0.out_en = 1'b1;

      vecs[0]  = '{16'h7FFF, 16'h0001, OP_ADD,  16'h8000, 4'b1010, 2};
      vecs[1]  = '{16'h0003, 16'h0005, OP_SUB,  16'hFFFE, 4'b0110, 2};
      vecs[2]  = '{16'hFFFF, 16'h0001, OP_ADD,  16'h0000, 4'b0101, 2};
      vecs[3]  = '{16'hF0F0, 16'h0FF0, OP_AND,  16'h00F0, 4'b0000, 2};
      vecs[4]  = '{16'hF000, 16'h000F, OP_OR,   16'hF00F, 4'b0010, 2};
      vecs[5]  = '{16'hAAAA, 16'hAAAA, OP_XOR,  16'h0000, 4'b0001, 2};
      vecs[6]  = '{16'h00FF, 16'h1234, OP_NOT,  16'hFF00, 4'b0010, 2};
      vecs[7]  = '{16'h8001, 16'h0000, OP_SHL,  16'h0002, 4'b0100, 2};
      vecs[8]  = '{16'h0003, 16'h0000, OP_SHR,  16'h0001, 4'b0100, 2};
      vecs[9]  = '{16'h1111, 16'h8000, OP_PASS, 16'h8000, 4'b0010, 2};
      vecs[10] = '{16'h0012, 16'h0034, OP_MUL,  16'h03A8, 4'b0000, 17};
      vecs[11] = '{16'h0100, 16'h0100, OP_MUL,  16'h0000, 4'b0101, 17};
      vecs[12] = '{16'h8000, 16'h0001, OP_SUB,  16'h7FFF, 4'b1000, 2};
      vecs[13] = '{16'hFFFF, 16'hFFFF, OP_MUL,  16'h0001, 4'b0100, 17};
      vecs[14] = '{16'h1234, 16'h5678, 4'hF,    16'h0001, 4'b0100, 2};
      vecs[15] = '{16'h0005, 16'h0005, OP_SUB,  16'h0000, 4'b0001, 2};

      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      chk("rst_busy", {31'd0, bif0.busy}, 32'd0);
      chk("rst_done", {31'd0, bif0.done}, 32'd0);
      chk("rst_flags", {28'd0, bif0.flags}, 32'd0);
      chk("rst_result", {16'd0, bus_out0}, 32'd0);

      for (int i = 0; i < 16; i++) begin
         load_ab(vecs[i].a, vecs[i].b);
         run_op(0, vecs[i].op, 1'b0, res, fl, lat);
         chk($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].res});
         chk($sformatf("vec%0d_flags", i), {28'd0, fl}, {28'd0, vecs[i].fl});
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      end

      // Accumulator chaining: result 5 + B 3, A register left at 0x0100.
      load_ab(16'h0100, 16'h0005);
      run_op(0, OP_PASS, 1'b0, res, fl, lat);
      chk("chain_seed", {16'd0, res}, 32'h0005);
      bif0.bus_in = 16'h0003;
      bif0.load_b = 1'b1;
      tick();
      bif0.load_b = 1'b0;
      run_op(0, OP_ADD, 1'b1, res, fl, lat);
      chk("chain_result", {16'd0, res}, 32'h0008);
      run_op(0, OP_ADD, 1'b0, res, fl, lat);
      chk("chain_a_kept", {16'd0, res}, 32'h0103);

      bif0.out_en = 1'b0;
      #1;
      chk("bus_released", {31'd0, (bus_out0 !== 16'h0103)}, 32'd1);
      bif0.out_en = 1'b1;
      #1;
      chk("bus_driven", {16'd0, bus_out0}, 32'h0103);

      // Load and start on the same edge: op sees the old A.
      load_ab(16'h0010, 16'h0001);
      bif0.bus_in = 16'h0020;
      bif0.load_a = 1'b1;
      run_op(0, OP_ADD, 1'b0, res, fl, lat);
      bif0.load_a = 1'b0;
      chk("ldstart_old", {16'd0, res}, 32'h0011);
      run_op(0, OP_ADD, 1'b0, res, fl, lat);
      chk("ldstart_new", {16'd0, res}, 32'h0021);

      // Load and start while MUL is running are ignored.
      load_ab(16'h0002, 16'h0003);
      bif0.op = OP_MUL;
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      lat = 1;
      repeat (3) begin tick(); lat++; end
      chk("mul_busy", {31'd0, bif0.busy}, 32'd1);
      chk("mul_bus_prev", {16'd0, bus_out0}, 32'h0021);
      bif0.bus_in = 16'h7777;
      bif0.load_a = 1'b1;
      bif0.op = OP_ADD;
      bif0.start = 1'b1;
      tick();
      lat++;
      bif0.load_a = 1'b0;
      bif0.start = 1'b0;
      while (bif0.done !== 1'b1 && lat < 40) begin tick(); lat++; end
      chk("mul_ign_latency", lat, 17);
      chk("mul_ign_result", {16'd0, bus_out0}, 32'h0006);
      done_cnt = 0;
      repeat (4) begin
         tick();
         if (bif0.done === 1'b1) done_cnt++;
      end
      chk("no_queued_start", done_cnt, 0);
      run_op(0, OP_ADD, 1'b0, res, fl, lat);
      chk("mul_ign_a_kept", {16'd0, res}, 32'h0005);

      // Reset in the middle of a multiply.
      load_ab(16'h0004, 16'h0005);
      bif0.op = OP_MUL;
      bif0.start = 1'b1;
      tick();
      bif0.start = 1'b0;
      repeat (5) tick();
      rst = 1'b0;
      tick();
      chk("midrst_busy", {31'd0, bif0.busy}, 32'd0);
      chk("midrst_result", {16'd0, bus_out0}, 32'd0);
      chk("midrst_flags", {28'd0, bif0.flags}, 32'd0);
      rst = 1'b1;
      done_cnt = 0;
      repeat (20) begin
         tick();
         if (bif0.done === 1'b1) done_cnt++;
      end
      chk("midrst_no_done", done_cnt, 0);
      run_op(0, OP_ADD, 1'b0, res, fl, lat);
      chk("midrst_ops_clr", {16'd0, res}, 32'd0);
      chk("midrst_ops_flg", {28'd0, fl}, 32'h1);

      // MUL_EN=0 instance: opcode 8 is illegal.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      load_ab(16'h0002, 16'h0003);
      run_op(1, OP_MUL, 1'b0, res, fl, lat);
      chk("nomul_result", {16'd0, res}, 32'd0);
      chk("nomul_flags", {28'd0, fl}, 32'd0);
      chk("nomul_latency", lat, 2);
      repeat (20) tick();
      run_op(1, OP_ADD, 1'b0, res, fl, lat);
      chk("nomul_add", {16'd0, res}, 32'h0005);
      run_op(1, OP_MUL, 1'b0, res, fl, lat);
      chk("nomul_held", {16'd0, res}, 32'h0005);
      chk("nomul_lat2", lat, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
